// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_REQ  = 3'd1,
    D_WAIT = 3'd2,
    I_REQ  = 3'd3,
    I_WAIT = 3'd4,
    DONE   = 3'd5
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Backing-memory request/response bus; the arbiter is master, the memory is slave.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises the MEM-stage data access and the instruction fetch onto one
// single-ported memory, one outstanding transaction at a time, data first.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              stall,
  mem_arbiter_if.master     mem,
  output logic [CNT_W-1:0]  stall_cnt
);

  arb_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              has_d_q, has_d_d;     // data port is being served
  logic              need_i_q, need_i_d;   // fetch port is being served
  logic [ADDR_W-1:0] i_addr_q, i_addr_d;   // fetch address parked behind a data access
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              dm_any;

  assign dm_any = dm_read | dm_write;

  // State and datapath registers; reset aborts any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      has_d_q     <= 1'b0;
      need_i_q    <= 1'b0;
      i_addr_q    <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      has_d_q     <= has_d_d;
      need_i_q    <= need_i_d;
      i_addr_q    <= i_addr_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state: data access first, then the fetch, then one advancing cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dm_any) state_d = D_REQ;
               else if (if_req) state_d = I_REQ;
      D_REQ:   if (mem.mem_gnt) state_d = D_WAIT;
      D_WAIT:  if (mem.mem_rvalid) state_d = need_i_q ? I_REQ : DONE;
      I_REQ:   if (mem.mem_gnt) state_d = I_WAIT;
      I_WAIT:  if (mem.mem_rvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, memory request registers, read-data capture and counter.
  always_comb begin
    mem_req_d   = (state_d == D_REQ) || (state_d == I_REQ);
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    has_d_d     = has_d_q;
    need_i_d    = need_i_q;
    i_addr_d    = i_addr_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (dm_any) begin
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_we_d    = dm_write;
          has_d_d     = 1'b1;
          need_i_d    = if_req;
          i_addr_d    = if_addr;
        end else if (if_req) begin
          mem_addr_d  = if_addr;
          mem_we_d    = 1'b0;
          has_d_d     = 1'b0;
          need_i_d    = 1'b1;
        end
      end
      D_WAIT: begin
        if (mem.mem_rvalid) begin
          // a store acknowledge carries no data worth keeping
          if (!mem_we_q) dm_rdata_d = mem.mem_rdata;
          if (need_i_q) begin
            mem_addr_d = i_addr_q;
            mem_we_d   = 1'b0;
          end
        end
      end
      I_WAIT: if (mem.mem_rvalid) if_rdata_d = mem.mem_rdata;
      default: ;
    endcase
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Outputs: stall is combinational in IDLE so the requesting cycle freezes too.
  always_comb begin
    stall   = ((state_q != IDLE) && (state_q != DONE)) ||
              ((state_q == IDLE) && (if_req | dm_any));
    if_done = (state_q == DONE) && need_i_q;
    dm_done = (state_q == DONE) && has_d_q;
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign if_rdata      = if_rdata_q;
  assign dm_rdata      = dm_rdata_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus random transactions against a memory responder and a
// transaction-level expectation (access order, stall cycle arithmetic).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_read, dm_write;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata;
  logic        if_done, dm_done, stall;
  logic [3:0]  stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] m_ifr, m_dmr;
  int          m_cnt;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .stall(stall),
    .mem(mif), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h1234_5678);
  endfunction

  function automatic logic [31:0] sat15(input int c);
    return (c > 15) ? 32'd15 : c[31:0];
  endfunction

  // One pipeline cycle with no requests.
  task automatic idle_cycle();
    if_req = 0; dm_read = 0; dm_write = 0;
    if_addr = $urandom; dm_addr = $urandom;
    #1;
    chk("idle_stall", stall, 0);
    chk("idle_req", mif.mem_req, 0);
    chk("idle_cnt", stall_cnt, sat15(m_cnt));
    @(negedge clk);
  endtask

  // One pipeline cycle's worth of requests, served by the memory responder
  // with gd grant-delay cycles and rdl extra response cycles per access.
  task automatic run_txn(input bit ir, input bit dr, input bit dw,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] wd, input int gd, input int rdl);
    logic [31:0] qa[$];
    bit          qw[$];
    logic [31:0] qd[$];
    logic [31:0] ca, cd;
    bit          cw, busy, done, dacc;
    int          gcnt, rcnt, stalls, reqs, exp_st, exp_req, cyc;
    dacc = dr | dw;
    busy = 0; done = 0; gcnt = 0; rcnt = 0; stalls = 0; reqs = 0; cyc = 0;
    ca = 0; cd = 0; cw = 0;
    if (dacc) begin qa.push_back(da); qw.push_back(dw); qd.push_back(wd); end
    if (ir)   begin qa.push_back(ia); qw.push_back(1'b0); qd.push_back(32'h0); end
    exp_st  = 1 + qa.size() * (2 + gd + rdl);
    exp_req = qa.size() * (1 + gd);
    if (dacc && !dw) m_dmr = rd_mem(da);
    if (ir) m_ifr = (dw && ia == da) ? wd : rd_mem(ia);
    m_cnt += exp_st;
    if_req = ir; dm_read = dr; dm_write = dw;
    if_addr = ia; dm_addr = da; dm_wdata = wd;
    while (!done && cyc < 200) begin
      #1;
      if (mif.mem_req === 1'b1) begin
        reqs++;
        if (qa.size() == 0) chk("spurious_req", mif.mem_req, 0);
        else begin
          chk("req_addr", mif.mem_addr, qa[0]);
          chk("req_we", mif.mem_we, qw[0]);
          if (qw[0]) chk("req_wdata", mif.mem_wdata, qd[0]);
        end
      end
      if (if_done === 1'b1 || dm_done === 1'b1) begin
        done = 1;
        chk("if_done", if_done, ir);
        chk("dm_done", dm_done, dacc);
        chk("done_stall", stall, 0);
        chk("if_rdata", if_rdata, m_ifr);
        chk("dm_rdata", dm_rdata, m_dmr);
        chk("stall_cycles", stalls, exp_st);
        chk("req_cycles", reqs, exp_req);
        chk("stall_cnt", stall_cnt, sat15(m_cnt));
      end else if (stall === 1'b1) stalls++;
      mif.mem_gnt = 0; mif.mem_rvalid = 0;
      if (!done) begin
        if (busy) begin
          if (rcnt == rdl) begin
            mif.mem_rvalid = 1;
            if (cw) begin mem[ca] = cd; mif.mem_rdata = $urandom; end
            else mif.mem_rdata = rd_mem(ca);
            busy = 0; gcnt = 0;
          end else rcnt++;
        end else if (mif.mem_req === 1'b1 && qa.size() != 0) begin
          if (gcnt == gd) begin
            mif.mem_gnt = 1; busy = 1; rcnt = 0;
            ca = qa.pop_front(); cw = qw.pop_front(); cd = qd.pop_front();
          end else gcnt++;
        end
      end
      // requester inputs are don't-care once the request has been taken
      if (cyc == 1) begin if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom; end
      if (done) begin if_req = 0; dm_read = 0; dm_write = 0; end
      cyc++;
      @(negedge clk);
    end
    if (!done) chk("timeout", done, 1);
  endtask

  initial begin
    int k, gd, rdl;
    logic [31:0] ia, da, wd;
    rst = 1; if_req = 0; dm_read = 0; dm_write = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0;
    mif.mem_gnt = 0; mif.mem_rvalid = 0; mif.mem_rdata = 0;
    m_ifr = 0; m_dmr = 0; m_cnt = 0;
    mem[32'h10]  = 32'h8C01_0004;
    mem[32'h100] = 32'hDEAD_BEEF;
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_req", mif.mem_req, 0);
    chk("rst_we", mif.mem_we, 0);
    chk("rst_addr", mif.mem_addr, 0);
    chk("rst_wdata", mif.mem_wdata, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_dm_done", dm_done, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_cnt", stall_cnt, 0);
    @(negedge clk); rst = 0;
    idle_cycle();

    // fetch only, then grant held low for 4 cycles, then load+fetch, then store
    run_txn(1, 0, 0, 32'h10, 32'h0, 32'h0, 0, 0);
    run_txn(1, 0, 0, 32'h24, 32'h0, 32'h0, 4, 0);
    run_txn(1, 1, 0, 32'h14, 32'h100, 32'h0, 0, 0);
    run_txn(0, 1, 1, 32'h0, 32'h200, 32'h55, 0, 0);
    chk("store_mem", rd_mem(32'h200), 32'h55);
    idle_cycle();

    // reset while waiting on a data response, late response afterwards
    dm_read = 1; dm_addr = 32'h300; dm_wdata = 32'h77; if_req = 1; if_addr = 32'h18;
    @(negedge clk); #1;
    chk("mid_req", mif.mem_req, 1);
    mif.mem_gnt = 1;
    @(negedge clk); mif.mem_gnt = 0; #1;
    chk("mid_wait_req", mif.mem_req, 0);
    chk("mid_wait_stall", stall, 1);
    rst = 1; dm_read = 0; if_req = 0; #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_req", mif.mem_req, 0);
    chk("mid_rst_addr", mif.mem_addr, 0);
    chk("mid_rst_wdata", mif.mem_wdata, 0);
    chk("mid_rst_dm_rdata", dm_rdata, 0);
    chk("mid_rst_if_rdata", if_rdata, 0);
    chk("mid_rst_cnt", stall_cnt, 0);
    m_cnt = 0; m_ifr = 0; m_dmr = 0;
    @(negedge clk); rst = 0;
    mif.mem_rvalid = 1; mif.mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk); mif.mem_rvalid = 0; #1;
    chk("late_dm_rdata", dm_rdata, 0);
    chk("late_if_rdata", if_rdata, 0);
    chk("late_dm_done", dm_done, 0);
    chk("late_stall", stall, 0);
    chk("late_req", mif.mem_req, 0);
    @(negedge clk);
    run_txn(1, 0, 0, 32'h10, 32'h0, 32'h0, 0, 0);

    // random mix of request patterns and memory latencies
    for (int n = 0; n < 40; n++) begin
      k   = $urandom_range(0, 5);
      gd  = $urandom_range(0, 2);
      rdl = $urandom_range(0, 2);
      ia  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      da  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      wd  = $urandom;
      case (k)
        0: idle_cycle();
        1: run_txn(1, 0, 0, ia, da, wd, gd, rdl);
        2: run_txn(0, 1, 0, ia, da, wd, gd, rdl);
        3: run_txn(0, 1'($urandom_range(0, 1)), 1, ia, da, wd, gd, rdl);
        4: run_txn(1, 1, 0, ia, da, wd, gd, rdl);
        default: run_txn(1, 1'($urandom_range(0, 1)), 1, ia, da, wd, gd, rdl);
      endcase
    end
    run_txn(1, 1, 0, 32'h10, 32'h100, 32'h0, 1, 1);
    #1;
    if (m_cnt > 15) chk("cnt_saturated", stall_cnt, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
